// File: rtl/pll_phase_ctrl_if.sv
// ---------------------------------------------------------------------------
// pll_phase_ctrl_if
//   Control-side bundle of the PLL phase-step initiator.
//
//   Request channel : req_valid / req_ready / req_sel / req_dir / req_steps
//   Status          : busy, done (1-cycle), err (1-cycle), steps_done
//   Readback        : pos_sel -> pos_out (combinational)
//
//   master : the control logic issuing shift requests
//   slave  : pll_phase_ctrl
// ---------------------------------------------------------------------------
interface pll_phase_ctrl_if #(
    parameter int CNT_W   = 8,
    parameter int PHASE_W = 10
);
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_sel;
    logic               req_dir;
    logic [CNT_W-1:0]   req_steps;

    logic               busy;
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   steps_done;

    logic [2:0]         pos_sel;
    logic [PHASE_W-1:0] pos_out;

    modport master (
        output req_valid, req_sel, req_dir, req_steps, pos_sel,
        input  req_ready, busy, done, err, steps_done, pos_out
    );

    modport slave (
        input  req_valid, req_sel, req_dir, req_steps, pos_sel,
        output req_ready, busy, done, err, steps_done, pos_out
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// pll_phase_ctrl
//   Dynamic phase-shift initiator for the GTP_PLL_E3 phase-step port.
//   Accepts "shift output k by N steps in direction d", waits for a stable
//   PLL lock, issues N timed active-low step pulses followed by a one-cycle
//   LOAD_PHASE strobe, and tracks the cumulative phase of all 5 outputs.
//
// Ports
//   clk, rst        controller clock, async active-high reset
//   bus (slave)     request / status / position readback bundle
//   i_pll_lock      PLL LOCK, asynchronous (2-FF synchronized here)
//   o_phase_sel     PLL PHASE_SEL, held from accept to next accept
//   o_phase_dir     PLL PHASE_DIR, held from accept to next accept
//   o_phase_step_n  PLL PHASE_STEP_N, active low
//   o_load_phase    PLL LOAD_PHASE, 1-cycle strobe
// ---------------------------------------------------------------------------
module pll_phase_ctrl #(
    parameter int CNT_W         = 8,
    parameter int PHASE_W       = 10,
    parameter int STEP_LOW_CYC  = 2,
    parameter int STEP_GAP_CYC  = 8,
    parameter int LOCK_WAIT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    pll_phase_ctrl_if.slave   bus,
    input  logic              i_pll_lock,
    output logic [2:0]        o_phase_sel,
    output logic              o_phase_dir,
    output logic              o_phase_step_n,
    output logic              o_load_phase
);

    localparam int NUM_OUT = 5;
    localparam int CYC_MAX = (STEP_LOW_CYC > STEP_GAP_CYC) ? STEP_LOW_CYC : STEP_GAP_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int LCK_W   = $clog2(LOCK_WAIT_CYC + 1);

    localparam logic [CYC_W-1:0] LO_LAST  = CYC_W'(STEP_LOW_CYC - 1);
    localparam logic [CYC_W-1:0] GAP_LAST = CYC_W'(STEP_GAP_CYC - 1);
    localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCK_WAIT_CYC);
    localparam logic [2:0]       SEL_MAX  = 3'(NUM_OUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_LO     = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_LOAD   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]         r_state;
    logic               r_lock_ff1;
    logic               r_lock_s;
    logic [LCK_W-1:0]   r_lock_cnt;
    logic [CYC_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_steps_done;
    logic [2:0]         r_phase_sel;
    logic               r_phase_dir;
    logic               r_step_n;
    logic               r_load;
    logic               r_done;
    logic               r_err;
    logic [PHASE_W-1:0] r_pos [NUM_OUT];

    logic               w_accept;
    logic               w_step_start;
    logic               w_abort;

    // ---------------------------------------------------------------------
    // Lock synchronizer and stability counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_ff1 <= 1'b0;
            r_lock_s   <= 1'b0;
        end else begin
            r_lock_ff1 <= i_pll_lock;
            r_lock_s   <= r_lock_ff1;
        end
    end

    // Saturates so WAIT_LOCK can compare for equality; any low cycle restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lock_cnt <= '0;
        else if (!r_lock_s)
            r_lock_cnt <= '0;
        else if (r_lock_cnt != LCK_MAX)
            r_lock_cnt <= r_lock_cnt + LCK_W'(1);
    end

    // ---------------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------------
    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // A step is issued (and counted) on the edge that enters STEP_LO, either
    // from WAIT_LOCK once lock is proven stable or at the end of a gap with
    // steps still outstanding.
    assign w_step_start = r_lock_s &&
                          (((r_state == S_WAIT) && (r_lock_cnt == LCK_MAX)) ||
                           ((r_state == S_GAP) && (r_cyc == GAP_LAST) &&
                            (r_steps_done < r_target)));

    // Lock loss once pulses have started aborts the sequence.
    assign w_abort = !r_lock_s &&
                     ((r_state == S_LO) || (r_state == S_GAP) || (r_state == S_LOAD));

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cyc        <= '0;
            r_target     <= '0;
            r_steps_done <= '0;
            r_phase_sel  <= 3'd0;
            r_phase_dir  <= 1'b0;
            r_step_n     <= 1'b1;
            r_load       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_load <= 1'b0;

            if (w_abort) begin
                r_state  <= S_ERR;
                r_err    <= 1'b1;
                r_step_n <= 1'b1;
            end else if (w_step_start) begin
                r_state      <= S_LO;
                r_step_n     <= 1'b0;
                r_cyc        <= '0;
                r_steps_done <= r_steps_done + CNT_W'(1);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_phase_sel  <= bus.req_sel;
                            r_phase_dir  <= bus.req_dir;
                            r_target     <= bus.req_steps;
                            r_steps_done <= '0;
                            r_state      <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (r_phase_sel > SEL_MAX) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else if (r_target == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // no timeout: waits as long as the PLL needs
                    end
                    S_LO: begin
                        if (r_cyc == LO_LAST) begin
                            r_state  <= S_GAP;
                            r_step_n <= 1'b1;
                            r_cyc    <= '0;
                        end else begin
                            r_cyc <= r_cyc + CYC_W'(1);
                        end
                    end
                    S_GAP: begin
                        // the "more steps" exit is taken via w_step_start
                        if (r_cyc == GAP_LAST) begin
                            r_state <= S_LOAD;
                            r_load  <= 1'b1;
                        end else begin
                            r_cyc <= r_cyc + CYC_W'(1);
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    S_ERR:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-output phase position, wraps modulo 2^PHASE_W
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++)
                r_pos[k] <= '0;
        end else if (w_step_start) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (r_phase_sel == 3'(k))
                    r_pos[k] <= r_phase_dir ? r_pos[k] + PHASE_W'(1)
                                            : r_pos[k] - PHASE_W'(1);
        end
    end

    always_comb begin
        bus.pos_out = '0;
        for (int k = 0; k < NUM_OUT; k++)
            if (bus.pos_sel == 3'(k))
                bus.pos_out = r_pos[k];
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.steps_done   = r_steps_done;

    assign o_phase_sel      = r_phase_sel;
    assign o_phase_dir      = r_phase_dir;
    assign o_phase_step_n   = r_step_n;
    assign o_load_phase     = r_load;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_phase_ctrl
//   Scoreboard bench: each accepted request pushes its expected outcome
//   (end kind, end cycle, step count, pulse timing, final position); a
//   monitor on the falling edge observes the PLL pins and pops/compares on
//   every done/err pulse.
// ---------------------------------------------------------------------------
module tb_pll_phase_ctrl;

    localparam int CNT_W   = 8;
    localparam int PHASE_W = 10;
    localparam int LO_C    = 2;
    localparam int GAP_C   = 8;
    localparam int LCK_C   = 16;
    localparam int PER     = LO_C + GAP_C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic [2:0] phase_sel;
    logic       phase_dir, phase_step_n, load_phase;

    pll_phase_ctrl_if #(.CNT_W(CNT_W), .PHASE_W(PHASE_W)) bus ();

    pll_phase_ctrl #(
        .CNT_W(CNT_W), .PHASE_W(PHASE_W), .STEP_LOW_CYC(LO_C),
        .STEP_GAP_CYC(GAP_C), .LOCK_WAIT_CYC(LCK_C)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .i_pll_lock     (pll_lock),
        .o_phase_sel    (phase_sel),
        .o_phase_dir    (phase_dir),
        .o_phase_step_n (phase_step_n),
        .o_load_phase   (load_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int sel;
        int dir;
        int nsteps;
        int pos;
        int t_first;
        int t_done;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    int   model_pos [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------------
    bit   m_prev_stepn = 1'b1;
    bit   m_prev_busy  = 1'b0;
    int   m_pulses, m_locyc, m_loads, m_first, m_last, m_tload;
    exp_t m_e;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_pulses = 0; m_locyc = 0; m_loads = 0; m_first = 0; m_last = 0; m_tload = 0;
            m_prev_stepn = 1'b1;
            m_prev_busy  = 1'b0;
        end else begin
            if (bus.busy && !m_prev_busy) acc_cnt++;
            m_prev_busy = bus.busy;
            if (m_prev_stepn && !phase_step_n) begin
                if (m_pulses == 0) m_first = cyc;
                else chk("step_period", cyc - m_last, PER);
                m_last = cyc;
                m_pulses++;
                if (exp_q.size() > 0) begin
                    chk("sel_hold", 32'(phase_sel), exp_q[0].sel);
                    chk("dir_hold", 32'(phase_dir), exp_q[0].dir);
                end
            end
            if (!phase_step_n) m_locyc++;
            if (load_phase) begin
                m_loads++;
                m_tload = cyc;
            end
            if (bus.done || bus.err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("end_kind", {30'd0, bus.done, bus.err}, m_e.is_err ? 2 'b01 : 2'b10);
                    chk("end_time", cyc, m_e.t_done);
                    chk("steps_done", 32'(bus.steps_done), m_e.nsteps);
                    chk("pulses", m_pulses, m_e.nsteps);
                    chk("low_cycles", m_locyc, m_e.nsteps * LO_C);
                    chk("loads", m_loads, (!m_e.is_err && m_e.nsteps > 0) ? 1 : 0);
                    if (m_loads > 0) chk("load_time", m_tload, m_e.t_done - 1);
                    if (m_e.nsteps > 0) chk("first_low", m_first, m_e.t_first);
                    chk("pos_end", 32'(bus.pos_out), m_e.pos);
                end
                m_pulses = 0; m_locyc = 0; m_loads = 0;
            end
            m_prev_stepn = phase_step_n;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    // Returns t = cycle number of the accepting clock edge.
    task automatic send(input int sel, input int dir, input int steps, output int t);
        int n;
        @(negedge clk);
        bus.req_sel   = 3'(sel);
        bus.req_dir   = dir[0];
        bus.req_steps = CNT_W'(steps);
        bus.pos_sel   = 3'(sel);
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", 0, 1);
        @(negedge clk);
        t = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic push(input bit is_err, input int sel, input int dir, input int nsteps,
                        input int t_first, input int t_done);
        exp_t e;
        if (sel < 5) model_pos[sel] = (model_pos[sel] + (dir != 0 ? nsteps : -nsteps)) & 1023;
        e.is_err  = is_err;
        e.sel     = sel;
        e.dir     = dir;
        e.nsteps  = nsteps;
        e.pos     = (sel < 5) ? model_pos[sel] : 0;
        e.t_first = t_first;
        e.t_done  = t_done;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input string tag, output int t);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            chk({tag, "_timeout"}, 0, 1);
            exp_q.delete();
        end
        t = cyc;
    endtask

    task automatic check_all_pos(input string tag);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.pos_sel = 3'(k);
            #1;
            chk(tag, 32'(bus.pos_out), (k < 5) ? model_pos[k] : 0);
        end
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    int t, t1, t2, tr, c_lock, acc0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_sel   = 3'd0;
        bus.req_dir   = 1'b0;
        bus.req_steps = '0;
        bus.pos_sel   = 3'd0;
        for (int k = 0; k < 5; k++) model_pos[k] = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_step_n", 32'(phase_step_n), 1);
        chk("rst_load", 32'(load_phase), 0);
        chk("rst_done_err", {30'd0, bus.done, bus.err}, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_sel_dir", {28'd0, phase_sel, phase_dir}, 0);
        chk("rst_steps_done", 32'(bus.steps_done), 0);
        rst = 1'b0;
        check_all_pos("rst_pos");

        // 1: lock stable, sel=2 +3
        pll_lock = 1'b1;
        repeat (25) @(negedge clk);
        send(2, 1, 3, t);
        push(0, 2, 1, 3, t + 2, t + 3 + 3 * PER);
        wait_ready("t1", tr);
        chk("t1_ready_time", tr, t + 4 + 3 * PER);

        // 2: lock rises shortly before request; must wait 16 synced-high cycles
        pll_lock = 1'b0;
        repeat (6) @(negedge clk);
        pll_lock = 1'b1;
        c_lock = cyc;
        repeat (3) @(negedge clk);
        send(0, 0, 1, t);
        // 2 sync stages + 16 counted cycles + 1 cycle to leave WAIT_LOCK
        push(0, 0, 0, 1, c_lock + 19, c_lock + 19 + PER + 1);
        wait_ready("t2", tr);

        // 3: lock drops in the 2nd gap of a 4-step request
        repeat (5) @(negedge clk);
        send(3, 1, 4, t);
        // pin low at T+15 -> synced low at T+17 -> err at T+18
        push(1, 3, 1, 2, t + 2, t + 18);
        repeat (15) @(negedge clk);
        pll_lock = 1'b0;
        wait_ready("t3", tr);
        chk("t3_ready", 32'(bus.req_ready), 1);
        pll_lock = 1'b1;
        repeat (25) @(negedge clk);

        // 4: invalid selector, zero steps
        send(5, 1, 4, t);
        push(1, 5, 1, 0, 0, t + 1);
        wait_ready("t4a", tr);
        check_all_pos("t4_pos");
        send(0, 1, 0, t);
        push(0, 0, 1, 0, 0, t + 1);
        wait_ready("t4b", tr);

        // 5: back-to-back with req_valid held high while busy
        acc0 = acc_cnt;
        @(negedge clk);
        bus.req_sel = 3'd1; bus.req_dir = 1'b1; bus.req_steps = CNT_W'(5);
        bus.pos_sel = 3'd1; bus.req_valid = 1'b1;
        @(negedge clk);
        t1 = cyc;
        push(0, 1, 1, 5, t1 + 2, t1 + 3 + 5 * PER);
        bus.req_dir = 1'b0; bus.req_steps = CNT_W'(3);
        wait_ready("t5a", tr);
        chk("b2b_ready_time", tr, t1 + 4 + 5 * PER);
        @(negedge clk);
        t2 = cyc;
        chk("b2b_second_accept", 32'(bus.busy), 1);
        push(0, 1, 0, 3, t2 + 2, t2 + 3 + 3 * PER);
        repeat (10) @(negedge clk);
        bus.req_valid = 1'b0;
        wait_ready("t5b", tr);
        repeat (3) @(negedge clk);
        chk("b2b_accepts", acc_cnt - acc0, 2);
        check_all_pos("t5_pos");

        // 6: reset in the middle of a low pulse
        send(4, 1, 3, t);
        repeat (2) @(negedge clk);
        chk("pre_rst_low", 32'(phase_step_n), 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_step_n", 32'(phase_step_n), 1);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        for (int k = 0; k < 5; k++) model_pos[k] = 0;
        check_all_pos("rst_mid_pos");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.req_ready), 1);

        // 7: normal operation after reset, retard wraps
        repeat (25) @(negedge clk);
        send(4, 0, 2, t);
        push(0, 4, 0, 2, t + 2, t + 3 + 2 * PER);
        wait_ready("t7", tr);
        check_all_pos("final_pos");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
